// File: rtl/shake_absorb_loader.sv
// SHAKE absorb loader: packs header-described message words into a rate-sized
// block with byte-accurate 0x1F/0x80 padding, then hands the block downstream.
module shake_absorb_loader #(
    parameter int WORD_W = 64,
    parameter int LEN_W  = 32
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    hdr_valid,
    output logic                                    hdr_ready,
    input  logic                                    hdr_mode,
    input  logic [LEN_W-1:0]                        hdr_len,
    input  logic                                    valid_in,
    output logic                                    ready_out,
    input  logic [WORD_W-1:0]                       data_in,
    output logic                                    blk_valid,
    input  logic                                    blk_ready,
    output logic [(1344/WORD_W)*WORD_W-1:0]         blk_data,
    output logic                                    blk_last,
    output logic                                    blk_mode
);
    localparam int BYTES          = WORD_W / 8;
    localparam int RATE128_WORDS  = 1344 / WORD_W;
    localparam int RATE256_WORDS  = 1088 / WORD_W;
    localparam int MAX_RATE_WORDS = RATE128_WORDS;
    localparam int WIDX_W         = $clog2(MAX_RATE_WORDS + 1);

    typedef enum logic [1:0] {IDLE, LOAD, PAD, HANDOFF} state_t;

    state_t                                   state, state_nxt;
    logic [MAX_RATE_WORDS-1:0][WORD_W-1:0]    buffer;
    logic                                     mode;
    logic [LEN_W-1:0]                         rem, rem_nxt;
    logic [WIDX_W-1:0]                        widx;
    logic                                     pad_pending, pad_nxt;
    logic                                     last_q;

    logic                                     take_hdr, wr_en, last_set, blk_take;
    logic [WORD_W-1:0]                        wr_word, load_word;
    logic [LEN_W-1:0]                         k;
    logic [WIDX_W-1:0]                        rate_m1;
    logic                                     at_end;

    assign rate_m1 = mode ? WIDX_W'(RATE256_WORDS - 1) : WIDX_W'(RATE128_WORDS - 1);
    assign at_end  = (widx == rate_m1);
    assign k       = (rem < LEN_W'(BYTES)) ? rem : LEN_W'(BYTES);

    // Bytes past the valid count are zeroed; the first one gets the domain byte.
    always_comb begin
        load_word = '0;
        for (int b = 0; b < BYTES; b++) begin
            if (LEN_W'(b) < k)
                load_word[b*8 +: 8] = data_in[b*8 +: 8];
            else if (LEN_W'(b) == k)
                load_word[b*8 +: 8] = 8'h1F;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        take_hdr  = 1'b0;
        wr_en     = 1'b0;
        wr_word   = '0;
        rem_nxt   = rem;
        pad_nxt   = pad_pending;
        last_set  = 1'b0;
        blk_take  = 1'b0;
        case (state)
            IDLE: begin
                if (hdr_valid) begin
                    take_hdr  = 1'b1;
                    state_nxt = (hdr_len != '0) ? LOAD : PAD;
                end
            end
            LOAD: begin
                if (valid_in) begin
                    wr_en   = 1'b1;
                    wr_word = load_word;
                    rem_nxt = rem - k;
                    if (k < LEN_W'(BYTES)) pad_nxt = 1'b0;
                    if (at_end)              state_nxt = HANDOFF;
                    else if (rem_nxt == '0)  state_nxt = PAD;
                end
            end
            PAD: begin
                wr_en   = 1'b1;
                wr_word = pad_pending ? WORD_W'(8'h1F) : '0;
                pad_nxt = 1'b0;
                if (at_end) state_nxt = HANDOFF;
            end
            HANDOFF: begin
                if (blk_ready) begin
                    blk_take  = 1'b1;
                    state_nxt = last_q ? IDLE : ((rem == '0) ? PAD : LOAD);
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Final pad bit: only once the 0x1F has already landed in this block.
        if (wr_en && at_end && !pad_nxt) begin
            wr_word[WORD_W-1] = 1'b1;
            last_set          = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buffer      <= '0;
            mode        <= 1'b0;
            rem         <= '0;
            widx        <= '0;
            pad_pending <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            if (take_hdr) begin
                mode        <= hdr_mode;
                rem         <= hdr_len;
                pad_pending <= 1'b1;
                widx        <= '0;
                last_q      <= 1'b0;
            end
            if (wr_en) begin
                buffer[widx] <= wr_word;
                widx         <= widx + 1'b1;
                rem          <= rem_nxt;
                pad_pending  <= pad_nxt;
                if (last_set) last_q <= 1'b1;
            end
            if (blk_take) begin
                buffer <= '0;
                widx   <= '0;
                last_q <= 1'b0;
            end
        end
    end

    assign hdr_ready = (state == IDLE)    && !rst;
    assign ready_out = (state == LOAD)    && !rst;
    assign blk_valid = (state == HANDOFF) && !rst;
    assign blk_data  = rst ? '0 : buffer;
    assign blk_last  = last_q && !rst;
    assign blk_mode  = mode && !rst;

endmodule
